// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : two-port arbiter/sequencer for the single-port data memory
// Revision     : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int MAX_WAIT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_p0,
    output logic              err,
    output logic              err_port
);

    localparam logic [ADDR_W:0] C_ADDR_LIMIT = (ADDR_W + 1)'(DEPTH_WORDS * 4);
    localparam logic [3:0]      C_MAX_WAIT   = 4'(MAX_WAIT);

    logic [3:0]        r_wait_cnt;
    logic              w_p0_win;
    logic              w_p1_win;
    logic              w_granted;
    logic              w_sel_we;
    logic              w_rejected;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_rdata_next;

    // Port 1 only overrides port 0 once it has been refused MAX_WAIT times.
    always_comb begin
        w_p1_win     = p1_req && (!p0_req || (r_wait_cnt >= C_MAX_WAIT));
        w_p0_win     = p0_req && !w_p1_win;
        w_granted    = w_p0_win || w_p1_win;
        w_sel_addr   = w_p1_win ? p1_addr  : p0_addr;
        w_sel_we     = w_p1_win ? p1_we    : p0_we;
        mem_wdata    = w_p1_win ? p1_wdata : p0_wdata;
        w_rejected   = w_granted &&
                       ((w_sel_addr[1:0] != 2'b00) || ({1'b0, w_sel_addr} >= C_ADDR_LIMIT));
        w_rdata_next = w_rejected ? '0 : mem_rdata;
    end

    assign p0_gnt   = w_p0_win;
    assign p1_gnt   = w_p1_win;
    assign stall_p0 = p0_req && !w_p0_win;
    assign mem_addr = w_sel_addr;
    assign mem_we   = rst && w_granted && w_sel_we && !w_rejected;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 4'd0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            err        <= 1'b0;
            err_port   <= 1'b0;
        end else begin
            p0_rvalid <= w_p0_win && !p0_we;
            p1_rvalid <= w_p1_win && !p1_we;
            if (w_p0_win && !p0_we) begin
                p0_rdata <= w_rdata_next;
            end
            if (w_p1_win && !p1_we) begin
                p1_rdata <= w_rdata_next;
            end
            err      <= w_rejected;
            err_port <= w_p1_win;
            if (w_p1_win || !p1_req) begin
                r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt != 4'hF) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed vector table plus randomized run against a model
// Revision        : 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int DEPTH_WORDS = 256;
    localparam int MAX_WAIT    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we, stall_p0, err, err_port;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_p0(stall_p0), .err(err), .err_port(err_port)
    );

    // Physical memory attached to the arbiter
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    // Reference model: grant rule, wait count as an integer, shadow memory
    logic [31:0] smem [0:255];
    int          m_wait;
    logic        m_g0, m_g1, m_rej, m_mem_we, m_sel_we;
    logic [31:0] m_addr, m_wdata;
    logic        m_rv0, m_rv1, m_err, m_ep;
    logic [31:0] m_rd0, m_rd1;

    always_comb begin
        m_g1     = p1_req && (!p0_req || m_wait >= MAX_WAIT);
        m_g0     = p0_req && !m_g1;
        m_addr   = m_g1 ? p1_addr : p0_addr;
        m_wdata  = m_g1 ? p1_wdata : p0_wdata;
        m_sel_we = m_g1 ? p1_we : p0_we;
        m_rej    = (m_g0 || m_g1) && ((m_addr % 4) != 0 || m_addr >= DEPTH_WORDS * 4);
        m_mem_we = rst && (m_g0 || m_g1) && m_sel_we && !m_rej;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wait <= 0;
            m_rv0 <= 1'b0; m_rv1 <= 1'b0;
            m_rd0 <= '0;   m_rd1 <= '0;
            m_err <= 1'b0; m_ep  <= 1'b0;
        end else begin
            m_rv0 <= m_g0 && !p0_we;
            m_rv1 <= m_g1 && !p1_we;
            if (m_g0 && !p0_we) m_rd0 <= m_rej ? 32'd0 : smem[m_addr[9:2]];
            if (m_g1 && !p1_we) m_rd1 <= m_rej ? 32'd0 : smem[m_addr[9:2]];
            m_err <= m_rej;
            m_ep  <= m_g1;
            if (m_mem_we) smem[m_addr[9:2]] <= m_wdata;
            if (p1_req && !m_g1) m_wait <= (m_wait < 15) ? m_wait + 1 : 15;
            else                 m_wait <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic a_req, input logic a_we, input logic [31:0] a_addr,
                         input logic [31:0] a_wd, input logic b_req, input logic b_we,
                         input logic [31:0] b_addr, input logic [31:0] b_wd);
        p0_req = a_req; p0_we = a_we; p0_addr = a_addr; p0_wdata = a_wd;
        p1_req = b_req; p1_we = b_we; p1_addr = b_addr; p1_wdata = b_wd;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 15)      rnd_addr = 32'($urandom_range(0, 31)) * 4;
        else if (r < 16) rnd_addr = 32'h3FC;
        else if (r < 18) rnd_addr = 32'($urandom_range(0, 127));
        else             rnd_addr = $urandom();
    endfunction

    typedef struct {
        logic        a_req, a_we;
        logic [31:0] a_addr, a_wd;
        logic        b_req, b_we;
        logic [31:0] b_addr, b_wd;
        logic        e_g0, e_g1, e_stall, e_mwe, e_rv0;
        logic [31:0] e_rd0;
        logic        e_rv1;
        logic [31:0] e_rd1;
        logic        e_err, e_ep;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic last_g0, last_g1;
        int   streak, nbad;

        vecs[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3FC, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h12, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h100000FF, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h100000FF, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10000008, 1'b0, 32'h0, 1'b0, 1'b0};

        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'h1000_0000 + 32'(i);
            smem[i] = 32'h1000_0000 + 32'(i);
        end

        // Reset: registered outputs clear, write request must not reach memory
        #2 rst = 1'b0;
        drive(1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        chk("rst_err", {err_port, err}, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_p0_gnt", 32'(p0_gnt), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wd,
                  vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wd);
            @(negedge clk);
            chk($sformatf("v%0d_p0_gnt", i), 32'(p0_gnt), 32'(vecs[i].e_g0));
            chk($sformatf("v%0d_p1_gnt", i), 32'(p1_gnt), 32'(vecs[i].e_g1));
            chk($sformatf("v%0d_stall", i), 32'(stall_p0), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_mwe));
            chk($sformatf("v%0d_p0_rvalid", i), 32'(p0_rvalid), 32'(vecs[i].e_rv0));
            chk($sformatf("v%0d_p0_rdata", i), p0_rdata, vecs[i].e_rd0);
            chk($sformatf("v%0d_p1_rvalid", i), 32'(p1_rvalid), 32'(vecs[i].e_rv1));
            chk($sformatf("v%0d_p1_rdata", i), p1_rdata, vecs[i].e_rd1);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
            if (vecs[i].e_err) chk($sformatf("v%0d_err_port", i), 32'(err_port), 32'(vecs[i].e_ep));
        end
        chk("misaligned_write_mem_word4", mem[4], 32'hDEADBEEF);

        // Contention: both ports held, port 1 forced through after MAX_WAIT refusals
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
            @(negedge clk);
            chk($sformatf("cont%0d_p0_gnt", c), 32'(p0_gnt), (c == 4) ? 32'd0 : 32'd1);
            chk($sformatf("cont%0d_p1_gnt", c), 32'(p1_gnt), (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_stall", c), 32'(stall_p0), (c == 4) ? 32'd1 : 32'd0);
        end

        // Reset in the middle of a granted read
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("pre_rst_p0_rvalid", 32'(p0_rvalid), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("midrst_p0_rdata", p0_rdata, 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("postrst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("postrst_p0_rdata", p0_rdata, 32'd0);

        // Randomized traffic against the reference model; requests held until granted
        last_g0 = 1'b1;
        last_g1 = 1'b1;
        streak  = 0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk); #1;
            if (!p0_req || last_g0) begin
                p0_req = ($urandom_range(0, 99) < 65);
                p0_we = $urandom_range(0, 1) == 1; p0_addr = rnd_addr(); p0_wdata = $urandom();
            end
            if (!p1_req || last_g1) begin
                p1_req = ($urandom_range(0, 99) < 45);
                p1_we = $urandom_range(0, 1) == 1; p1_addr = rnd_addr(); p1_wdata = $urandom();
            end
            @(negedge clk);
            chk("rnd_p0_gnt", 32'(p0_gnt), 32'(m_g0));
            chk("rnd_p1_gnt", 32'(p1_gnt), 32'(m_g1));
            chk("rnd_stall", 32'(stall_p0), 32'(p0_req && !m_g0));
            chk("rnd_mem_we", 32'(mem_we), 32'(m_mem_we));
            if (m_g0 || m_g1) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            chk("rnd_p0_rvalid", 32'(p0_rvalid), 32'(m_rv0));
            chk("rnd_p0_rdata", p0_rdata, m_rd0);
            chk("rnd_p1_rvalid", 32'(p1_rvalid), 32'(m_rv1));
            chk("rnd_p1_rdata", p1_rdata, m_rd1);
            chk("rnd_err", 32'(err), 32'(m_err));
            if (m_err) chk("rnd_err_port", 32'(err_port), 32'(m_ep));
            streak = (p1_req && !p1_gnt) ? streak + 1 : 0;
            chk("rnd_p1_progress", 32'(streak <= MAX_WAIT), 32'd1);
            last_g0 = m_g0;
            last_g1 = m_g1;
        end

        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== smem[i]) nbad++;
        chk("final_mem_image_bad_words", 32'(nbad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory (256 x 32-bit, combinational read, synchronous write). It shares that memory between port 0, the pipeline MEM stage, and port 1, a loader/debug master.
- Per cycle, one requester is granted and steered onto the memory pins.
- Read data is registered and returned one cycle later with a valid strobe.
- Bad addresses are screened so they never corrupt memory.
- Port 0 has priority; a bounded-wait counter guarantees port 1 forward progress.

## Interface
- DATA_W, 32, data width of memory and both ports
- ADDR_W, 32, byte-address width of both ports
- DEPTH_WORDS, 256, memory depth; valid byte addresses are 0 .. DEPTH_WORDS*4-1
- MAX_WAIT, 4, cycles port 1 may be refused before it is forced ahead of port 0 (range 1..15)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- p0_req  input  1  port 0 access request, held until granted
- p0_we  input  1  port 0 write (1) / read (0)
- p0_addr  input  ADDR_W  port 0 byte address
- p0_wdata  input  DATA_W  port 0 write data
- p0_gnt  output  1  port 0 granted this cycle (combinational)
- p0_rvalid  output  1  port 0 read data valid (registered)
- p0_rdata  output  DATA_W  port 0 read data (registered)
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: identical to port 0, for port 1
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory byte address; memory indexes with addr[9:2]
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory combinational read data
- stall_p0  output  1  p0_req && !p0_gnt; drives the pipeline stall
- err  output  1  one-cycle pulse: the previous-cycle granted access was rejected
- err_port  output  1  port of the rejected access, valid while err=1

## Operation
- **Grant selection, combinational, each cycle:**
  - p1 wins if p1_req && (!p0_req || wait_cnt >= MAX_WAIT).
  - Otherwise p0 wins if p0_req.
  - Otherwise no grant.
- **Steering:**
  - mem_addr and mem_wdata follow the winning port.
  - With no grant, they hold port 0 values and mem_we=0.
- **wait_cnt** is 4-bit and saturating:
  - increments when p1_req && !p1_gnt;
  - clears to 0 when p1_gnt or !p1_req.
  - After a forced p1 grant, port 0 regains priority next cycle.
- **Rejection:** a granted access is rejected when addr[1:0] != 0 (misaligned) or addr >= DEPTH_WORDS*4 (out of range).
  - A rejected write drives mem_we=0.
  - A rejected read returns rdata=0.
  - The grant is still given so the requester completes.
- **Writes:** mem_we = winner's we && !rejected. Writes are complete at the grant edge and produce no rvalid.
- **Reads:** at the grant edge, the winner's pN_rdata <= mem_rdata (0 if rejected) and pN_rvalid <= 1.
  - The other port's rvalid is 0.
  - rdata holds its value until the next read on that port.
- **err:** err <= rejected && granted; err_port <= winning port. Flags both reads and writes.
- **Reset (rst=0), asynchronous:**
  - wait_cnt=0
  - p0_rvalid=p1_rvalid=0
  - p0_rdata=p1_rdata=0
  - err=0, err_port=0
  - gnt/stall/mem_* remain combinational from inputs, with mem_we forced 0 while rst=0.
  - Reset mid-read discards the pending rvalid.

## Timing
- Grant latency 0: request and grant occur in the same cycle.
- Read latency 1: rvalid high the cycle after the grant, for exactly one cycle per granted read.
- Back-to-back reads on one port give consecutive rvalid pulses.
- A write followed by a read of the same address in the next cycle returns the new data.
- With p0 requesting continuously, p1 is granted within MAX_WAIT+1 cycles of raising p1_req.
- Simultaneous requests with wait_cnt < MAX_WAIT: p0 wins, stall_p0=0, and p1 retries.
- No combinational path from mem_rdata to any output except through the rdata registers.

## Test plan
- **Reset values:** assert rst=0 mid-read.
  - Required: rvalid=0, rdata=0, err=0 immediately, and no rvalid after release.
- **Port 0 write then read:** p0 writes 0xDEADBEEF to 0x10, then reads 0x10.
  - Required: p0_gnt=1 both cycles, and p0_rvalid=1 with p0_rdata=0xDEADBEEF in the cycle after the read.
- **Contention, MAX_WAIT=4:** p0_req and p1_req held high.
  - Required: p0 granted cycles 0-3, p1 granted cycle 4, p0 cycle 5, and stall_p0=1 only in cycle 4.
- **Idle port 0:** p1 read of 0x3FC with p0 idle.
  - Required: p1_gnt same cycle, p1_rvalid next cycle with the stored word, p0_rvalid=0.
- **Misaligned write:** p0 write to 0x12.
  - Required: mem_we=0, memory unchanged, err=1 with err_port=0 next cycle.
- **Out-of-range read:** p1 read of 0x400.
  - Required: p1_rvalid=1, p1_rdata=0, err=1 with err_port=1.
